// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one cmd in, one bus transaction, one rsp out.
// Define AXI_TIMEOUT_EN to build the bus-wait watchdog (TIMEOUT_CYCLES per bus state).
module axi4_lite_cmd_master #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0]                  state;
  logic                        aw_valid, w_valid, ar_valid;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;

  // All handshake outputs are decoded from registered state, never from READY inputs.
  assign cmd_ready     = (state == IDLE) & ~rst;
  assign rsp_valid     = (state == RSP);
  assign M_AXI_BREADY  = (state == WR_RESP);
  assign M_AXI_RREADY  = (state == RD_DATA);
  assign M_AXI_AWVALID = aw_valid;
  assign M_AXI_WVALID  = w_valid;
  assign M_AXI_ARVALID = ar_valid;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;

`ifdef AXI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt, tmo_now;
  logic [2:0]       state_prev;
  logic             bus_state, tmo_hit, rsp_to_q;

  // A state change restarts the count, so each bus state gets its own budget.
  assign bus_state = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_DATA);
  assign tmo_now   = (state != state_prev) ? '0 : tmo_cnt;
  assign tmo_hit   = bus_state && (tmo_now == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_to_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_prev <= IDLE;
      tmo_cnt    <= '0;
    end else begin
      state_prev <= state;
      tmo_cnt    <= tmo_now + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      ar_valid  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
`ifdef AXI_TIMEOUT_EN
      rsp_to_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state     <= cmd_write ? WR_REQ : RD_REQ;
          addr_q    <= cmd_addr;
          wdata_q   <= cmd_wdata;
          wstrb_q   <= cmd_wstrb;
          rsp_write <= cmd_write;
          rsp_rdata <= '0;
          rsp_resp  <= 2'b00;
          aw_valid  <= cmd_write;
          w_valid   <= cmd_write;
          ar_valid  <= ~cmd_write;
        end
        WR_REQ: begin
          if (M_AXI_AWREADY) aw_valid <= 1'b0;
          if (M_AXI_WREADY)  w_valid  <= 1'b0;
          if ((!aw_valid || M_AXI_AWREADY) && (!w_valid || M_AXI_WREADY))
            state <= WR_RESP;
        end
        WR_RESP: if (M_AXI_BVALID) begin
          rsp_resp <= M_AXI_BRESP;
          state    <= RSP;
        end
        RD_REQ: if (M_AXI_ARREADY) begin
          ar_valid <= 1'b0;
          state    <= RD_DATA;
        end
        RD_DATA: if (M_AXI_RVALID) begin
          rsp_rdata <= M_AXI_RDATA;
          rsp_resp  <= M_AXI_RRESP;
          state     <= RSP;
        end
        RSP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef AXI_TIMEOUT_EN
      if (state == IDLE) rsp_to_q <= 1'b0;
      // Watchdog overrides whatever the bus state decided this cycle.
      if (tmo_hit) begin
        aw_valid  <= 1'b0;
        w_valid   <= 1'b0;
        ar_valid  <= 1'b0;
        rsp_rdata <= '0;
        rsp_resp  <= 2'b10;
        rsp_to_q  <= 1'b1;
        state     <= RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Bench for axi4_lite_cmd_master: table vectors, random commands vs a memory/latency model,
// and hand sequences for async reset and (with AXI_TIMEOUT_EN) the watchdog.
module tb_axi4_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi4_lite_cmd_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          awd, wd, bd, ard, rd, rspd;
    logic [1:0]  resp;
    logic        keep_cv;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] slv_mem [0:7];
  logic [31:0] model_mem [0:7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Issue one command and act as the slave with the delays in v; checks protocol and response.
  task automatic run_cmd(input vec_t v, input logic [31:0] exp_rdata, input int exp_lat);
    int n, lat, viol, aw_n, w_n, b_n, ar_n, r_n, bw, rw, rs;
    logic aw_d, w_d, b_d, ar_d, r_d, seen, done, applied;
    logic hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_rsp;
    logic [15:0] aw_a, ar_a, cur_awaddr, cur_araddr;
    logic [31:0] w_dat, cur_wdata;
    logic [3:0]  w_st, cur_wstrb;
    logic [35:0] snap;
    n = 0; lat = -1; viol = 0; aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    bw = 0; rw = 0; rs = 0; aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
    seen = 0; done = 0; applied = 0; aw_a = '0; ar_a = '0; w_dat = '0; w_st = '0; snap = '0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    step();
    cmd_valid = v.keep_cv; cmd_write = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_wstrb = ~v.wstrb;
    chk("first_valid", {awvalid, wvalid, arvalid}, v.wr ? 3'b110 : 3'b001);
    for (int c = 1; c < 300 && !done; c++) begin
      awready = v.wr && !aw_d && (c - 1 >= v.awd);
      wready  = v.wr && !w_d && (c - 1 >= v.wd);
      arready = !v.wr && !ar_d && (c - 1 >= v.ard);
      bresp = v.resp; rresp = v.resp;
      if (aw_d && w_d && !b_d) begin bvalid = (bw >= v.bd); bw++; end else bvalid = 0;
      if (ar_d && !r_d) begin rvalid = (rw >= v.rd); rw++; end else rvalid = 0;
      rdata = rvalid ? slv_mem[ar_a[4:2]] : 32'h0;
      if (rsp_valid) begin
        if (!seen) begin seen = 1; lat = c; snap = {rsp_write, rsp_rdata, rsp_resp, rsp_timeout}; end
        else if (snap !== {rsp_write, rsp_rdata, rsp_resp, rsp_timeout}) viol++;
        rsp_ready = (rs >= v.rspd); rs++;
      end else rsp_ready = 0;
      if (cmd_ready) viol++;
      if ((awvalid && aw_d) || (wvalid && w_d) || (arvalid && ar_d)) viol++;
      if (awvalid && (awaddr !== v.addr || awprot !== 3'b000)) viol++;
      if (arvalid && (araddr !== v.addr || arprot !== 3'b000)) viol++;
      if (wvalid && (wdata !== v.wdata || wstrb !== v.wstrb)) viol++;
      hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_b = bvalid && bready;
      hs_ar = arvalid && arready; hs_r = rvalid && rready; hs_rsp = rsp_valid && rsp_ready;
      cur_awaddr = awaddr; cur_araddr = araddr; cur_wdata = wdata; cur_wstrb = wstrb;
      step();
      if (hs_aw) begin aw_d = 1; aw_n++; aw_a = cur_awaddr; end
      if (hs_w)  begin w_d = 1; w_n++; w_dat = cur_wdata; w_st = cur_wstrb; end
      if (hs_b)  begin b_d = 1; b_n++; end
      if (hs_ar) begin ar_d = 1; ar_n++; ar_a = cur_araddr; end
      if (hs_r)  begin r_d = 1; r_n++; end
      if (aw_d && w_d && !applied) begin
        applied = 1;
        slv_mem[aw_a[4:2]] = merge(slv_mem[aw_a[4:2]], w_dat, w_st);
      end
      if (hs_rsp) done = 1;
    end
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rsp_ready = 0; cmd_valid = 0;
    chk("rsp_done", done, 1);
    chk("latency", lat, exp_lat);
    chk("protocol", viol, 0);
    chk("handshakes", {4'(aw_n), 4'(w_n), 4'(b_n), 4'(ar_n), 4'(r_n)},
        v.wr ? 20'h11100 : 20'h00011);
    chk("rsp_write", snap[35], v.wr);
    chk("rsp_rdata", snap[34:3], exp_rdata);
    chk("rsp_resp", snap[2:1], v.resp);
    chk("rsp_timeout", snap[0], 0);
    chk("idle_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    vec_t tbl [7];
    vec_t v;
    int n, elat;
    logic [31:0] erd;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = '0; rresp = '0; rdata = '0;
    for (int i = 0; i < 8; i++) begin slv_mem[i] = '0; model_mem[i] = '0; end
    slv_mem[1] = 32'h1234_5678; model_mem[1] = 32'h1234_5678;

    //           wr addr      wdata          strb  awd wd bd ard rd rspd resp  kcv exp_rdata      lat
    tbl[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0,         3};
    tbl[1] = '{1'b1, 16'h0014, 32'hCAFEF00D, 4'hF, 0, 4, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0,         7};
    tbl[2] = '{1'b0, 16'h0004, 32'h0,        4'h0, 0, 0, 0, 0, 3, 0, 2'b10, 1'b0, 32'h12345678,  6};
    tbl[3] = '{1'b0, 16'h0010, 32'h0,        4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'hDEADBEEF,  3};
    tbl[4] = '{1'b1, 16'h0010, 32'h11223344, 4'h5, 3, 0, 1, 0, 0, 0, 2'b11, 1'b0, 32'h0,         7};
    tbl[5] = '{1'b0, 16'h0010, 32'h0,        4'h0, 0, 0, 0, 0, 0, 5, 2'b00, 1'b1, 32'hDE22BE44,  3};
    tbl[6] = '{1'b1, 16'h0008, 32'h0BADCAFE, 4'hC, 2, 2, 0, 2, 0, 1, 2'b01, 1'b0, 32'h0,         5};

    #2;
    chk("reset_ctrl", {cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_timeout,
                       awvalid, wvalid, bready, arvalid, rready}, 11'h0);
    chk("reset_data", {rsp_rdata, awaddr, wstrb}, 52'h0);
    @(negedge clk); rst = 0;
    step();
    chk("ready_out_of_reset", cmd_ready, 1);

    foreach (tbl[i]) begin
      if (tbl[i].wr) model_mem[tbl[i].addr[4:2]] = merge(model_mem[tbl[i].addr[4:2]], tbl[i].wdata, tbl[i].wstrb);
      run_cmd(tbl[i], tbl[i].exp_rdata, tbl[i].exp_lat);
    end

    // Asynchronous reset while a read address is pending.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0008; arready = 0;
    step();
    cmd_valid = 0;
    chk("arvalid_before_rst", arvalid, 1);
    step();
    #2 rst = 1;
    #1 chk("async_rst_drop", {arvalid, rready, rsp_valid, cmd_ready}, 4'b0000);
    @(negedge clk); rst = 0;
    step();
    chk("idle_after_rst", {cmd_ready, arvalid, rsp_valid}, 3'b100);

    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.addr = 16'($urandom_range(0, 5) * 4);
      v.wdata = $urandom; v.wstrb = 4'($urandom_range(0, 15));
      v.awd = $urandom_range(0, 3); v.wd = $urandom_range(0, 3); v.bd = $urandom_range(0, 2);
      v.ard = $urandom_range(0, 3); v.rd = $urandom_range(0, 3); v.rspd = $urandom_range(0, 2);
      v.resp = 2'($urandom_range(0, 3)); v.keep_cv = 1'($urandom_range(0, 1));
      v.exp_rdata = '0; v.exp_lat = 0;
      if (v.wr) begin
        model_mem[v.addr[4:2]] = merge(model_mem[v.addr[4:2]], v.wdata, v.wstrb);
        erd = '0;
        elat = 3 + ((v.awd > v.wd) ? v.awd : v.wd) + v.bd;
      end else begin
        erd = model_mem[v.addr[4:2]];
        elat = 3 + v.ard + v.rd;
      end
      run_cmd(v, erd, elat);
    end

`ifdef AXI_TIMEOUT_EN
    // Slave never accepts AW or W: watchdog must abort after 16 cycles.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0018; cmd_wdata = 32'h5555AAAA; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 0;
    n = 0;
    while (awvalid && n < 100) begin n++; step(); end
    chk("tmo_valid_cycles", n, 16);
    chk("tmo_rsp", {wvalid, rsp_valid, rsp_timeout, rsp_resp}, 5'b01110);
    chk("tmo_rdata", rsp_rdata, 0);
    rsp_ready = 1; step(); rsp_ready = 0;
    chk("tmo_idle", cmd_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
